// File: rtl/csa_pkg.sv
// csa_pkg: width helpers and carry-save tree sizing shared by the tree and the accumulator pipeline.
//   clog2      - ceiling log2 (0 for 1)
//   out_width  - accumulator width: operand width + growth for operand count and beats per packet
//   csa_next   - operand count after one row of 3:2 compressors
//   csa_count  - operand count entering a given row
//   csa_rows   - number of 3:2 rows needed to reach two vectors
package csa_pkg;
  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction
  function automatic int out_width(input int iw, input int n, input int beats);
    return iw + clog2(n) + clog2(beats);
  endfunction
  // each full triple becomes a sum/carry pair; leftover one or two operands pass through
  function automatic int csa_next(input int n);
    return 2 * (n / 3) + n % 3;
  endfunction
  function automatic int csa_count(input int n, input int row);
    int c;
    c = n;
    for (int i = 0; i < row; i++) c = csa_next(c);
    return c;
  endfunction
  function automatic int csa_rows(input int n);
    int c;
    int r;
    c = n;
    r = 0;
    while (c > 2) begin
      c = csa_next(c);
      r++;
    end
    return r;
  endfunction
endpackage

// File: rtl/csa_tree_nto2.sv
// csa_tree_nto2: combinational carry-save tree reducing p_num_in unsigned operands to a sum and a carry vector.
//   data  in  p_num_in*p_input_width  operand k at [k*p_input_width +: p_input_width]
//   sum   out p_out_width             sum vector
//   carry out p_out_width             carry vector (sum + carry = operand total)
module csa_tree_nto2
  import csa_pkg::*;
#(
  parameter int p_num_in = 8,
  parameter int p_input_width = 14,
  parameter int p_out_width = p_input_width + clog2(p_num_in)
) (
  input  logic [p_num_in*p_input_width-1:0] data,
  output logic [p_out_width-1:0]            sum,
  output logic [p_out_width-1:0]            carry
);
  localparam int rows = csa_rows(p_num_in);
  genvar r, j;
  for (r = 0; r <= rows; r++) begin : g_row
    localparam int n = csa_count(p_num_in, r);
    logic [p_out_width-1:0] v [n];
    if (r == 0) begin : g_in
      for (j = 0; j < n; j++) begin : g_op
        assign v[j] = p_out_width'(data[j*p_input_width +: p_input_width]);
      end
    end else begin : g_csa
      localparam int pn = csa_count(p_num_in, r - 1);
      localparam int t = pn / 3;
      for (j = 0; j < t; j++) begin : g_fa
        logic [p_out_width-1:0] a, b, c;
        assign a = g_row[r-1].v[3*j];
        assign b = g_row[r-1].v[3*j+1];
        assign c = g_row[r-1].v[3*j+2];
        assign v[2*j] = a ^ b ^ c;
        // the top carry bit is dropped: the operand total always fits p_out_width
        assign v[2*j+1] = ((a & b) | (a & c) | (b & c)) << 1;
      end
      for (j = 0; j < pn % 3; j++) begin : g_pass
        assign v[2*t+j] = g_row[r-1].v[3*t+j];
      end
    end
  end
  assign sum = g_row[rows].v[0];
  assign carry = g_row[rows].v[1];
endmodule

// File: rtl/csa_acc_tree_pipe.sv
// csa_acc_tree_pipe: two-stage pipeline; stage 1 registers the CSA tree result, stage 2 accumulates beats per packet with saturation.
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_data/i_valid/i_last input beat (p_num_in operands), o_ready accepts it
//   i_clr                 synchronous clear of pipeline and partial packet
//   o_sum/o_ovf/o_valid   packet total, saturation flag; i_ready accepts it
module csa_acc_tree_pipe
  import csa_pkg::*;
#(
  parameter int p_num_in = 8,
  parameter int p_input_width = 14,
  parameter int p_max_beats = 4,
  localparam int p_out_width = out_width(p_input_width, p_num_in, p_max_beats)
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic [p_num_in*p_input_width-1:0]  i_data,
  input  logic                               i_valid,
  input  logic                               i_last,
  output logic                               o_ready,
  input  logic                               i_clr,
  output logic [p_out_width-1:0]             o_sum,
  output logic                               o_ovf,
  output logic                               o_valid,
  input  logic                               i_ready
);
  logic en;
  logic [p_out_width-1:0] tree_sum, tree_carry;
  logic s1_valid, s1_last;
  logic [p_out_width-1:0] s1_sum, s1_carry;
  logic [p_out_width-1:0] acc, beat, base, res;
  logic [p_out_width:0] total;
  logic first, pkt_ovf, sat;
  csa_tree_nto2 #(
    .p_num_in(p_num_in),
    .p_input_width(p_input_width),
    .p_out_width(p_out_width)
  ) u_tree (
    .data(i_data),
    .sum(tree_sum),
    .carry(tree_carry)
  );
  assign en = !(o_valid && !i_ready) && !i_clr;
  assign o_ready = en && i_rst_n;
  // the beat total fits p_out_width, so the sum/carry merge wraps exactly
  assign beat = s1_sum + s1_carry;
  assign base = first ? '0 : acc;
  assign total = {1'b0, base} + {1'b0, beat};
  // once saturated, the packet stays pinned at all ones
  assign sat = total[p_out_width] || pkt_ovf;
  assign res = sat ? '1 : total[p_out_width-1:0];
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_last <= 1'b0;
      s1_sum <= '0;
      s1_carry <= '0;
      acc <= '0;
      first <= 1'b1;
      pkt_ovf <= 1'b0;
      o_sum <= '0;
      o_ovf <= 1'b0;
      o_valid <= 1'b0;
    end else if (i_clr) begin
      s1_valid <= 1'b0;
      first <= 1'b1;
      pkt_ovf <= 1'b0;
      o_valid <= 1'b0;
    end else if (en) begin
      s1_valid <= i_valid;
      s1_last <= i_last;
      s1_sum <= tree_sum;
      s1_carry <= tree_carry;
      o_valid <= s1_valid && s1_last;
      if (s1_valid) begin
        acc <= res;
        first <= s1_last;
        pkt_ovf <= !s1_last && sat;
        if (s1_last) begin
          o_sum <= res;
          o_ovf <= sat;
        end
      end
    end
  end
endmodule
